// File: rtl/comm_pkg.sv
// ---------------------------------------------------------------------------
// comm_pkg
// Shared definitions for the receive-side frame sync / SECDED decode stage.
//   sync_state_t      : frame synchroniser state encoding
//   DEFAULT_SYNC_WORD : frame sync pattern used when the top is not overridden
//   DATA_POS          : Hamming position feeding each data_out bit, LSB first
// ---------------------------------------------------------------------------
package comm_pkg;

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } sync_state_t;

   localparam logic [15:0] DEFAULT_SYNC_WORD = 16'hF628;

   localparam int DATA_BITS = 11;

   // data bit k is taken from Hamming position DATA_POS[k] (codeword bit POS-1)
   localparam logic [3:0] DATA_POS [DATA_BITS] = '{
      4'd3, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15
   };

endpackage

// File: rtl/secded_dec_15_11.sv
// ---------------------------------------------------------------------------
// secded_dec_15_11
// Purely combinational Hamming(15,11) + overall parity decoder.
//   code_word  in  16 : received word, bit i-1 = Hamming position i, bit 15
//                       = overall even parity
//   data       out 11 : extracted (and, for single errors, corrected) data
//   err_corr   out  1 : single error detected and corrected
//   err_uncorr out  1 : double error detected, data passed uncorrected
// ---------------------------------------------------------------------------
module secded_dec_15_11
   import comm_pkg::*;
(
   input  logic [15:0] code_word,
   output logic [10:0] data,
   output logic        err_corr,
   output logic        err_uncorr
);

   logic [3:0]  syndrome;
   logic        parity;
   logic [15:0] fixed;

   // Syndrome is the XOR of the positions of all set bits; an odd overall
   // parity means a single error that the syndrome locates (syndrome 0 means
   // the overall parity bit itself flipped). Even parity with a non-zero
   // syndrome is a double error, which is left untouched.
   always_comb begin
      syndrome   = '0;
      parity     = ^code_word;
      fixed      = code_word;
      data       = '0;
      err_corr   = 1'b0;
      err_uncorr = 1'b0;

      for (int i = 1; i <= 15; i++) begin
         if (code_word[i-1]) begin
            syndrome = syndrome ^ 4'(i);
         end
      end

      if (parity) begin
         err_corr = 1'b1;
         if (syndrome == 4'd0) begin
            fixed[15] = ~code_word[15];
         end else begin
            fixed[syndrome - 4'd1] = ~code_word[syndrome - 4'd1];
         end
      end else if (syndrome != 4'd0) begin
         err_uncorr = 1'b1;
      end

      for (int k = 0; k < DATA_BITS; k++) begin
         data[k] = fixed[DATA_POS[k] - 4'd1];
      end
   end

endmodule

// File: rtl/frame_sync_decoder.sv
// ---------------------------------------------------------------------------
// frame_sync_decoder
// Finds and tracks frame sync words in the incoming word stream and SECDED
// decodes the payload words of locked frames.
//   clk_10       in   1 : sole clock, rising edge
//   reset        in   1 : asynchronous, active-high
//   in_word      in  16 : incoming channel word
//   in_valid     in   1 : in_word accepted on this edge
//   data_out     out 11 : decoded payload data
//   data_valid   out  1 : one-cycle pulse per decoded word
//   frame_start  out  1 : first payload word of a frame
//   err_corr     out  1 : decoded word had a corrected single error
//   err_uncorr   out  1 : decoded word had an uncorrectable double error
//   locked       out  1 : synchroniser is in LOCKED
//   corr_count   out 16 : saturating count of corrected words
//   uncorr_count out 16 : saturating count of uncorrectable words
//   frame_count  out 16 : wrapping count of locked frames with a good sync
// ---------------------------------------------------------------------------
module frame_sync_decoder
   import comm_pkg::*;
#(
   parameter logic [15:0] SYNC_WORD  = DEFAULT_SYNC_WORD,
   parameter int          SYNC_TOL   = 1,
   parameter int          FRAME_LEN  = 8,
   parameter int          LOCK_COUNT = 2,
   parameter int          LOSS_COUNT = 3
)
(
   input  logic        clk_10,
   input  logic        reset,
   input  logic [15:0] in_word,
   input  logic        in_valid,
   output logic [10:0] data_out,
   output logic        data_valid,
   output logic        frame_start,
   output logic        err_corr,
   output logic        err_uncorr,
   output logic        locked,
   output logic [15:0] corr_count,
   output logic [15:0] uncorr_count,
   output logic [15:0] frame_count
);

   localparam int CW = $clog2(FRAME_LEN + 1);
   localparam int HW = $clog2(LOCK_COUNT + 1);
   localparam int MW = $clog2(LOSS_COUNT + 1);

   // word_cnt == SYNC_SLOT marks the word that must carry the next sync
   localparam logic [CW-1:0] SYNC_SLOT   = CW'(FRAME_LEN);
   localparam logic [HW-1:0] HITS_TARGET = HW'(LOCK_COUNT);
   localparam logic [MW-1:0] MISS_LIMIT  = MW'(LOSS_COUNT);

   sync_state_t   state, state_n;
   logic [CW-1:0] word_cnt, word_cnt_n;
   logic [HW-1:0] hits, hits_n;
   logic [MW-1:0] misses, misses_n;

   logic [4:0]    sync_dist;
   logic          sync_hit;
   logic          emit;
   logic          emit_first;
   logic          good_sync;

   logic [10:0]   dec_data;
   logic          dec_corr;
   logic          dec_uncorr;

   secded_dec_15_11 u_dec (
      .code_word  (in_word),
      .data       (dec_data),
      .err_corr   (dec_corr),
      .err_uncorr (dec_uncorr)
   );

   // Sync match tolerates up to SYNC_TOL flipped bits against the pattern.
   always_comb begin
      sync_dist = '0;
      for (int i = 0; i < 16; i++) begin
         sync_dist = sync_dist + 5'(in_word[i] ^ SYNC_WORD[i]);
      end
      sync_hit = (32'(sync_dist) <= SYNC_TOL);
   end

   // Synchroniser state register; only accepted words move anything.
   always_ff @(posedge clk_10 or posedge reset) begin
      if (reset) begin
         state    <= SEARCH;
         word_cnt <= '0;
         hits     <= '0;
         misses   <= '0;
      end else begin
         state    <= state_n;
         word_cnt <= word_cnt_n;
         hits     <= hits_n;
         misses   <= misses_n;
      end
   end

   // Next-state logic. word_cnt counts payload words since the last sync
   // slot; in LOCKED a missed sync still re-aligns the frame (flywheel) until
   // LOSS_COUNT consecutive misses drop lock.
   always_comb begin
      state_n    = state;
      word_cnt_n = word_cnt;
      hits_n     = hits;
      misses_n   = misses;
      emit       = 1'b0;
      emit_first = 1'b0;
      good_sync  = 1'b0;

      if (in_valid) begin
         case (state)
            SEARCH: begin
               if (sync_hit) begin
                  word_cnt_n = '0;
                  misses_n   = '0;
                  if (HITS_TARGET == HW'(1)) begin
                     state_n = LOCKED;
                     hits_n  = '0;
                  end else begin
                     state_n = VERIFY;
                     hits_n  = HW'(1);
                  end
               end
            end

            VERIFY: begin
               if (word_cnt != SYNC_SLOT) begin
                  word_cnt_n = word_cnt + CW'(1);
               end else begin
                  word_cnt_n = '0;
                  if (!sync_hit) begin
                     state_n = SEARCH;
                     hits_n  = '0;
                  end else if (hits + HW'(1) == HITS_TARGET) begin
                     state_n  = LOCKED;
                     hits_n   = '0;
                     misses_n = '0;
                  end else begin
                     hits_n = hits + HW'(1);
                  end
               end
            end

            LOCKED: begin
               if (word_cnt != SYNC_SLOT) begin
                  emit       = 1'b1;
                  emit_first = (word_cnt == '0);
                  word_cnt_n = word_cnt + CW'(1);
               end else begin
                  word_cnt_n = '0;
                  if (sync_hit) begin
                     misses_n  = '0;
                     good_sync = 1'b1;
                  end else if (misses + MW'(1) == MISS_LIMIT) begin
                     state_n  = SEARCH;
                     misses_n = '0;
                     hits_n   = '0;
                  end else begin
                     misses_n = misses + MW'(1);
                  end
               end
            end

            default: begin
               state_n    = SEARCH;
               word_cnt_n = '0;
               hits_n     = '0;
               misses_n   = '0;
            end
         endcase
      end
   end

   assign locked = (state == LOCKED);

   // Output register and statistics. Pulses and flags last one cycle;
   // data_out holds the last decoded word between pulses.
   always_ff @(posedge clk_10 or posedge reset) begin
      if (reset) begin
         data_out     <= '0;
         data_valid   <= 1'b0;
         frame_start  <= 1'b0;
         err_corr     <= 1'b0;
         err_uncorr   <= 1'b0;
         corr_count   <= '0;
         uncorr_count <= '0;
         frame_count  <= '0;
      end else begin
         data_valid  <= emit;
         frame_start <= emit_first;
         err_corr    <= emit & dec_corr;
         err_uncorr  <= emit & dec_uncorr;
         if (emit) begin
            data_out <= dec_data;
         end
         if (emit && dec_corr && corr_count != 16'hFFFF) begin
            corr_count <= corr_count + 16'd1;
         end
         if (emit && dec_uncorr && uncorr_count != 16'hFFFF) begin
            uncorr_count <= uncorr_count + 16'd1;
         end
         if (good_sync) begin
            frame_count <= frame_count + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_frame_sync_decoder.sv
// ---------------------------------------------------------------------------
// tb_frame_sync_decoder
// Directed, table-driven bench for frame_sync_decoder (FRAME_LEN=4) plus a
// second instance with FRAME_LEN=255 used to reach counter saturation.
// ---------------------------------------------------------------------------
module tb_frame_sync_decoder;

   localparam logic [15:0] SYNC  = 16'hF628;
   localparam logic [15:0] PAY   = 16'hDA16;
   localparam logic [15:0] PAY1E = 16'hDA06;
   localparam logic [15:0] PAY2E = 16'hDA02;
   localparam logic [10:0] DATA  = 11'h5A3;

   logic        clk_10;
   logic        reset;
   logic [15:0] in_word;
   logic        in_valid;
   logic [10:0] data_out;
   logic        data_valid, frame_start, err_corr, err_uncorr, locked;
   logic [15:0] corr_count, uncorr_count, frame_count;

   logic [15:0] sat_word;
   logic        sat_valid;
   logic [10:0] sat_data_out;
   logic        sat_data_valid, sat_frame_start, sat_err_corr, sat_err_uncorr, sat_locked;
   logic [15:0] sat_corr_count, sat_uncorr_count, sat_frame_count;

   int checks = 0;
   int errors = 0;
   logic [15:0] exp_frames;

   frame_sync_decoder #(
      .SYNC_WORD(SYNC), .SYNC_TOL(1), .FRAME_LEN(4), .LOCK_COUNT(2), .LOSS_COUNT(3)
   ) dut (
      .clk_10(clk_10), .reset(reset), .in_word(in_word), .in_valid(in_valid),
      .data_out(data_out), .data_valid(data_valid), .frame_start(frame_start),
      .err_corr(err_corr), .err_uncorr(err_uncorr), .locked(locked),
      .corr_count(corr_count), .uncorr_count(uncorr_count), .frame_count(frame_count)
   );

   frame_sync_decoder #(
      .SYNC_WORD(SYNC), .SYNC_TOL(1), .FRAME_LEN(255), .LOCK_COUNT(2), .LOSS_COUNT(3)
   ) dut_sat (
      .clk_10(clk_10), .reset(reset), .in_word(sat_word), .in_valid(sat_valid),
      .data_out(sat_data_out), .data_valid(sat_data_valid), .frame_start(sat_frame_start),
      .err_corr(sat_err_corr), .err_uncorr(sat_err_uncorr), .locked(sat_locked),
      .corr_count(sat_corr_count), .uncorr_count(sat_uncorr_count), .frame_count(sat_frame_count)
   );

   initial clk_10 = 1'b0;
   always #5 clk_10 = ~clk_10;

   typedef struct {
      logic [15:0] word;
      logic        valid;
      logic        fs;
      logic        corr;
      logic        uncorr;
      logic        lck;
      logic [10:0] data;
   } vec_t;

   vec_t vecs [16];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic [15:0] w);
      in_word  = w;
      in_valid = 1'b1;
      @(posedge clk_10);
      #1;
   endtask

   task automatic idleCycles(input int n);
      in_valid = 1'b0;
      repeat (n) begin
         @(posedge clk_10);
         #1;
      end
   endtask

   task automatic applySat(input logic [15:0] w);
      sat_word  = w;
      sat_valid = 1'b1;
      @(posedge clk_10);
      #1;
   endtask

   // One locked frame: 4 clean payload words then the given sync-slot word.
   task automatic sendFrame(input string tag, input logic [15:0] sw,
                            input logic exp_lck, input logic [15:0] exp_fc);
      applyStimulus(PAY);
      checkOutput({tag, "_first"}, {29'd0, data_valid, frame_start, 1'b0},
                  {29'd0, 1'b1, 1'b1, 1'b0});
      repeat (3) applyStimulus(PAY);
      applyStimulus(sw);
      checkOutput({tag, "_locked"}, {31'd0, locked}, {31'd0, exp_lck});
      checkOutput({tag, "_frames"}, {16'd0, frame_count}, {16'd0, exp_fc});
   endtask

   initial begin
      #20_000_000;
      $display("[TB] FAIL watchdog timeout");
      $fatal(1, "[TB] simulation did not finish");
   end

   initial begin
      // clean stream, sync tolerance while locked, single and double errors
      vecs[0]  = '{SYNC,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'h000};
      vecs[1]  = '{PAY,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'h000};
      vecs[2]  = '{PAY,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'h000};
      vecs[3]  = '{PAY,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'h000};
      vecs[4]  = '{PAY,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'h000};
      vecs[5]  = '{SYNC,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 11'h000};
      vecs[6]  = '{PAY,    1'b1, 1'b1, 1'b0, 1'b0, 1'b1, DATA};
      vecs[7]  = '{PAY,    1'b1, 1'b0, 1'b0, 1'b0, 1'b1, DATA};
      vecs[8]  = '{PAY,    1'b1, 1'b0, 1'b0, 1'b0, 1'b1, DATA};
      vecs[9]  = '{PAY,    1'b1, 1'b0, 1'b0, 1'b0, 1'b1, DATA};
      vecs[10] = '{16'hF629, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 11'h000};
      vecs[11] = '{PAY1E,  1'b1, 1'b1, 1'b1, 1'b0, 1'b1, DATA};
      vecs[12] = '{PAY2E,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 11'h5A0};
      vecs[13] = '{PAY,    1'b1, 1'b0, 1'b0, 1'b0, 1'b1, DATA};
      vecs[14] = '{PAY,    1'b1, 1'b0, 1'b0, 1'b0, 1'b1, DATA};
      vecs[15] = '{SYNC,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 11'h000};

      in_word   = '0;
      in_valid  = 1'b0;
      sat_word  = '0;
      sat_valid = 1'b0;
      reset     = 1'b1;
      repeat (2) @(posedge clk_10);
      #1;
      reset = 1'b0;
      #1;

      checkOutput("reset_outputs",
                  {21'd0, data_valid, frame_start, err_corr, err_uncorr, locked, data_out},
                  32'd0);
      checkOutput("reset_counts", {corr_count, uncorr_count}, 32'd0);
      checkOutput("reset_frames", {16'd0, frame_count}, 32'd0);

      for (int i = 0; i < 16; i++) begin
         applyStimulus(vecs[i].word);
         checkOutput($sformatf("vec%0d", i),
                     {16'd0, data_valid, frame_start, err_corr, err_uncorr, locked,
                      (data_valid ? data_out : 11'd0)},
                     {16'd0, vecs[i].valid, vecs[i].fs, vecs[i].corr, vecs[i].uncorr,
                      vecs[i].lck, vecs[i].data});
      end
      checkOutput("corr_count_after_table", {16'd0, corr_count}, 32'd1);
      checkOutput("uncorr_count_after_table", {16'd0, uncorr_count}, 32'd1);
      // good syncs counted in LOCKED so far: the 16'hF629 slot and the last sync
      exp_frames = 16'd2;
      checkOutput("frames_after_table", {16'd0, frame_count}, {16'd0, exp_frames});

      // flywheel over two missed syncs, then a good sync
      sendFrame("fly_miss1", 16'h0000, 1'b1, exp_frames);
      sendFrame("fly_miss2", 16'h0000, 1'b1, exp_frames);
      exp_frames = exp_frames + 16'd1;
      sendFrame("fly_good", SYNC, 1'b1, exp_frames);

      // three consecutive misses drop lock at the third
      sendFrame("loss1", 16'h0000, 1'b1, exp_frames);
      sendFrame("loss2", 16'h0000, 1'b1, exp_frames);
      sendFrame("loss3", 16'h0000, 1'b0, exp_frames);
      applyStimulus(PAY);
      checkOutput("search_no_output", {31'd0, data_valid}, 32'd0);

      // in_valid gaps inside frames must not shift the alignment
      applyStimulus(SYNC);
      idleCycles(2);
      checkOutput("gap_verify_quiet", {30'd0, data_valid, locked}, 32'd0);
      applyStimulus(PAY);
      applyStimulus(PAY);
      idleCycles(3);
      applyStimulus(PAY);
      applyStimulus(PAY);
      idleCycles(1);
      applyStimulus(SYNC);
      checkOutput("gap_lock", {31'd0, locked}, 32'd1);
      applyStimulus(PAY);
      checkOutput("gap_first_word", {20'd0, data_valid, frame_start, data_out},
                  {20'd0, 1'b1, 1'b1, DATA});
      idleCycles(2);
      checkOutput("gap_pulse_drops", {30'd0, data_valid, frame_start}, 32'd0);
      applyStimulus(PAY);
      applyStimulus(PAY);
      idleCycles(1);
      applyStimulus(PAY);
      idleCycles(2);
      applyStimulus(SYNC);
      exp_frames = exp_frames + 16'd1;
      checkOutput("gap_sync_slot", {14'd0, data_valid, locked, frame_count},
                  {14'd0, 1'b0, 1'b1, exp_frames});
      applyStimulus(PAY);
      checkOutput("gap_next_frame", {20'd0, data_valid, frame_start, data_out},
                  {20'd0, 1'b1, 1'b1, DATA});

      // asynchronous reset mid-frame clears everything without a clock edge
      applyStimulus(PAY);
      checkOutput("pre_reset_valid", {31'd0, data_valid}, 32'd1);
      reset = 1'b1;
      #2;
      checkOutput("async_reset_outputs",
                  {21'd0, data_valid, frame_start, err_corr, err_uncorr, locked, data_out},
                  32'd0);
      checkOutput("async_reset_counts", {corr_count, uncorr_count}, 32'd0);
      checkOutput("async_reset_frames", {16'd0, frame_count}, 32'd0);
      @(posedge clk_10);
      #1;
      reset = 1'b0;
      applyStimulus(SYNC);
      checkOutput("relock_first_sync", {31'd0, locked}, 32'd0);
      repeat (4) applyStimulus(PAY);
      applyStimulus(SYNC);
      checkOutput("relock_second_sync", {31'd0, locked}, 32'd1);

      // two-bit-off word at the VERIFY sync slot sends the FSM back to SEARCH
      reset = 1'b1;
      #2;
      reset = 1'b0;
      applyStimulus(16'hF629);
      repeat (4) applyStimulus(PAY);
      applyStimulus(16'hF62B);
      checkOutput("tol2_rejected", {31'd0, locked}, 32'd0);
      applyStimulus(SYNC);
      checkOutput("tol2_restart", {31'd0, locked}, 32'd0);
      repeat (4) applyStimulus(PAY);
      applyStimulus(SYNC);
      checkOutput("tol2_relock", {31'd0, locked}, 32'd1);

      // saturation of corr_count on the long-frame instance
      in_valid = 1'b0;
      applySat(SYNC);
      repeat (255) applySat(PAY1E);
      applySat(SYNC);
      checkOutput("sat_locked", {31'd0, sat_locked}, 32'd1);
      for (int f = 0; f < 257; f++) begin
         for (int k = 0; k < 255; k++) begin
            applySat(PAY1E);
            if (f == 256 && k == 253) begin
               checkOutput("sat_65534", {16'd0, sat_corr_count}, 32'h0000FFFE);
            end
         end
         applySat(SYNC);
      end
      checkOutput("sat_65535", {16'd0, sat_corr_count}, 32'h0000FFFF);
      applySat(PAY1E);
      checkOutput("sat_hold", {14'd0, sat_data_valid, sat_err_corr, sat_corr_count},
                  {14'd0, 1'b1, 1'b1, 16'hFFFF});
      sat_valid = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/frame_sync_decoder.md
# frame_sync_decoder

Receive-side stage directly downstream of `channel`: consumes its 16-bit word stream, finds and tracks frame sync words, and SECDED-decodes each payload word (Hamming(15,11) plus overall parity) into 11 data bits. It flags corrected and uncorrectable words and keeps saturating error counters for the board display. It runs in the `clk_10` domain, the same clock at which `channel` delivers words.

## Interface
- `SYNC_WORD`, 16'hF628: frame sync pattern.
- `SYNC_TOL`, 1: maximum Hamming distance still accepted as a sync match.
- `FRAME_LEN`, 8: payload words per frame, at least 1.
- `LOCK_COUNT`, 2: consecutive correctly spaced syncs needed to lock, at least 1.
- `LOSS_COUNT`, 3: consecutive missed syncs that drop lock, at least 1.

- `clk_10`  in  1: sole clock, rising edge.
- `reset`  in  1: asynchronous, active-high.
- `in_word`  in  16: word from `channel_output`.
- `in_valid`  in  1: `in_word` is accepted on each edge where this is high.
- `data_out`  out  11: decoded payload data.
- `data_valid`  out  1: one-cycle pulse for each decoded word.
- `frame_start`  out  1: qualifies the first payload word of a frame.
- `err_corr`  out  1: qualifies `data_valid`; a single error was corrected.
- `err_uncorr`  out  1: qualifies `data_valid`; a double error was detected.
- `locked`  out  1: FSM is in LOCKED.
- `corr_count`  out  16: saturating count of corrected words.
- `uncorr_count`  out  16: saturating count of uncorrectable words.
- `frame_count`  out  16: count of frames with a good sync; wraps.

## Operation
- Codeword layout: bit i-1 holds Hamming position i, for i = 1..15. Parity bits sit at positions 1, 2, 4 and 8. Bit 15 is overall even parity over all 16 bits.
- Data mapping: `data_out[0..10]` come from positions 3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15, in that order.
- Decode inputs: syndrome s is the XOR of the position indices of all set bits 0..14; p is the XOR of all 16 bits.
- Decode cases:
  - s=0, p=0: clean word.
  - p=1: single error. Flip position s, or flip bit 15 when s=0. Set `err_corr`.
  - s≠0, p=0: double error. Pass data uncorrected. Set `err_uncorr`.
- Sync match: popcount(`in_word` ^ `SYNC_WORD`) ≤ `SYNC_TOL`.
- All counting below is in accepted words only; cycles with `in_valid` low leave all state unchanged.
- FSM states and transitions:
  - SEARCH: nothing is output. On a sync match, go to VERIFY with hits=1. If `LOCK_COUNT`=1, go directly to LOCKED.
  - VERIFY: skip `FRAME_LEN` words without output. The next word is the sync slot. On a match, increment hits; when hits = `LOCK_COUNT`, go to LOCKED. On a mismatch, return to SEARCH; that word is not re-examined as a sync.
  - LOCKED, payload slots: decode the `FRAME_LEN` payload words and output each one.
  - LOCKED, sync slot: on a match, clear misses and increment `frame_count`. On a mismatch, increment misses. When misses reach `LOSS_COUNT`, go to SEARCH. Otherwise stay in LOCKED (flywheel) and treat the slot as a sync position.
- `frame_start` is high with the first payload word after every sync slot in LOCKED, whether that slot was matched or flywheeled.
- `corr_count` and `uncorr_count` increment on their flags and saturate at 16'hFFFF.

## Timing
- Latency: `data_out`, `data_valid` and the flags are registered and appear 1 cycle after the edge that accepted the word.
- `locked` rises on the edge that accepts the locking sync word. It falls on the edge that accepts the final missed sync.
- Counters update on the same edge as the corresponding `data_valid`.
- Reset values: every output is 0, the FSM is in SEARCH, and hits, misses and the word counter are 0.
- Reset asserted mid-frame: outputs clear immediately, without waiting for a clock edge. The in-flight `data_valid` is lost.

## Structure
- Package `comm_pkg` holds:
  - the FSM state enum (SEARCH, VERIFY, LOCKED);
  - the data-position mapping constants;
  - the default `SYNC_WORD`.
- Sub-module `secded_dec_15_11` is purely combinational. It takes the 16-bit word and returns data, `err_corr` and `err_uncorr`.
- `frame_sync_decoder` holds the FSM, the word counter, the output register and the counters.

## Test plan
Unless a line says otherwise, the bench uses `FRAME_LEN`=4, `LOCK_COUNT`=2, `LOSS_COUNT`=3, `SYNC_TOL`=1, and payload 16'hDA16, which encodes 11'h5A3.

- Clean stream: send sync, 4 payload words, sync, 4 payload words. Expect `locked` at the second sync. The following 4 words come out as `data_out`=11'h5A3 with no flags, and `frame_start` is high on the first of them.
- Single error: payload 16'hDA06 (position 5 flipped) while locked. Expect `data_out`=11'h5A3, `err_corr`=1, `corr_count` +1.
- Double error: payload 16'hDA02 (positions 3 and 5 flipped). Expect `err_uncorr`=1 and `uncorr_count` +1.
- Sync tolerance: 16'hF629 (1 bit off) is accepted as sync. 16'hF62B (2 bits off) at the VERIFY sync slot returns the FSM to SEARCH.
- Loss of lock, flywheel and `in_valid` gaps:
  - While locked, replace 2 sync words with 16'h0000. `locked` stays high, `frame_start` still pulses, and `frame_count` does not advance on those frames.
  - Replace 3 consecutive sync words. `locked` falls at the third.
  - Gaps of `in_valid`=0 inserted inside frames do not shift the alignment.
- Reset mid-frame, then saturation:
  - Assert `reset` mid-frame. All outputs are 0 at once, and the block relocks after 2 syncs.
  - Preload 65,535 corrected words; one more leaves `corr_count` at 16'hFFFF.
